// File: rtl/fpga_spi_slave_regs_if.sv
// SPI pins and register-file outputs of fpga_spi_slave_regs, bundled as one bus.
// "slave" is the block's view; "master" is the view of whatever drives the SPI pins
// and observes the register outputs.
interface fpga_spi_slave_regs_if #(
    parameter int unsigned N_REG = 16
) ();
    logic                   spi_sclk;
    logic                   spi_mosi;
    logic                   spi_ss_n;
    logic                   spi_miso;
    logic                   spi_miso_oe;
    logic [N_REG*16-1:0]    regs_out;
    logic                   wr_stb;
    logic [5:0]             wr_idx;

    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_ss_n,
        output spi_miso,
        output spi_miso_oe,
        output regs_out,
        output wr_stb,
        output wr_idx
    );

    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_ss_n,
        input  spi_miso,
        input  spi_miso_oe,
        input  regs_out,
        input  wr_stb,
        input  wr_idx
    );
endinterface

// File: rtl/fpga_spi_slave_regs.sv
// SPI mode-0 slave giving an SPI master read/write access to N_REG 16-bit registers.
// Frame: 32 bits MSB first, {W, addr[14:0], data[15:0]}. All SPI pins are
// oversampled in the clk_clk domain (clk_clk >= 8x spi_sclk).
// Optional feature macro: FPGA_SPI_SLAVE_READBACK_EN enables MISO readback;
// without it spi_miso and spi_miso_oe are tied low.
module fpga_spi_slave_regs #(
    parameter logic [14:0] BASE_ADDR = 15'h0000,
    parameter int unsigned N_REG     = 16
) (
    input  logic                  clk_clk,
    input  logic                  rst_reset_n,
    fpga_spi_slave_regs_if.slave  bus
);
    localparam int unsigned REG_W  = 16;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned CMP_W  = 17;
    localparam logic [CMP_W-1:0] BASE_EXT = CMP_W'(BASE_ADDR);
    localparam logic [CMP_W-1:0] N_EXT    = CMP_W'(N_REG);
    localparam logic [CNT_W-1:0] LAST_CMD_BIT  = CNT_W'(15);
    localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(31);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        DATA    = 2'd2,
        WAIT_SS = 2'd3
    } state_t;

    state_t             state_q, state_d;

    logic [1:0]         sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic               sclk_prev_q, ss_prev_q;
    logic               sclk_s, mosi_s, ss_s;
    logic               sclk_rise_c, ss_fall_c;

    logic [CNT_W-1:0]   bit_cnt_q;
    logic [REG_W-1:0]   sr_q;
    logic [REG_W-1:0]   shift_word_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [CMP_W-1:0]   offset_c;
    logic               hit_c;
    logic [IDX_W-1:0]   idx_c;

    logic               is_wr_q, hit_q;
    logic [IDX_W-1:0]   idx_q;

    logic               cnt_clr_c, shift_c, decode_c, frame_done_c, wr_en_c;

    logic [REG_W-1:0]   regs_q [N_REG];
    logic               wr_stb_q;
    logic [IDX_W-1:0]   wr_idx_q;

    // Two-flop synchronizers plus one history flop for edge detection.
    // ss_n resets to "selected" so a frame already in progress at reset release
    // is not mistaken for a fresh falling edge.
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            ss_sync_q   <= 2'b00;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
            ss_sync_q   <= {ss_sync_q[0], bus.spi_ss_n};
            sclk_prev_q <= sclk_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
        end
    end

    assign sclk_s      = sclk_sync_q[1];
    assign mosi_s      = mosi_sync_q[1];
    assign ss_s        = ss_sync_q[1];
    assign sclk_rise_c = sclk_s & ~sclk_prev_q;
    assign ss_fall_c   = ~ss_s & ss_prev_q;

    // Shift register contents including the bit being sampled this cycle;
    // holds the command at the 16th sample and the data at the 32nd.
    assign shift_word_c = {sr_q[REG_W-2:0], mosi_s};
    assign addr_c       = shift_word_c[ADDR_W-1:0];
    // Addresses below BASE_ADDR wrap to a large offset and miss.
    assign offset_c     = CMP_W'(addr_c) - BASE_EXT;
    assign hit_c        = (offset_c < N_EXT);
    assign idx_c        = IDX_W'(offset_c);

    // FSM state register.
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle datapath controls.
    always_comb begin
        state_d      = state_q;
        cnt_clr_c    = 1'b0;
        shift_c      = 1'b0;
        decode_c     = 1'b0;
        frame_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall_c) begin
                    state_d   = CMD;
                    cnt_clr_c = 1'b1;
                end
            end
            CMD: begin
                if (ss_s) begin
                    state_d = IDLE;
                end else if (sclk_rise_c) begin
                    shift_c = 1'b1;
                    if (bit_cnt_q == LAST_CMD_BIT) begin
                        state_d  = DATA;
                        decode_c = 1'b1;
                    end
                end
            end
            DATA: begin
                if (ss_s) begin
                    state_d = IDLE;
                end else if (sclk_rise_c) begin
                    shift_c = 1'b1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d      = WAIT_SS;
                        frame_done_c = 1'b1;
                    end
                end
            end
            WAIT_SS: begin
                if (ss_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_en_c = frame_done_c & is_wr_q & hit_q;

    // Bit counter, MOSI shift register and latched command decode.
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            bit_cnt_q <= '0;
            sr_q      <= '0;
            is_wr_q   <= 1'b0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            if (cnt_clr_c) begin
                bit_cnt_q <= '0;
            end else if (shift_c) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (shift_c) begin
                sr_q <= shift_word_c;
            end
            if (decode_c) begin
                is_wr_q <= shift_word_c[REG_W-1];
                hit_q   <= hit_c;
                idx_q   <= idx_c;
            end
        end
    end

    // Register file with write strobe, committed on the 32nd sample of a write hit.
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            for (int unsigned k = 0; k < N_REG; k++) begin
                regs_q[k] <= '0;
            end
            wr_stb_q <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_REG; k++) begin
                if (wr_en_c && (idx_q == IDX_W'(k))) begin
                    regs_q[k] <= shift_word_c;
                end
            end
            wr_stb_q <= wr_en_c;
            if (wr_en_c) begin
                wr_idx_q <= idx_q;
            end
        end
    end

    for (genvar k = 0; k < N_REG; k++) begin : g_flat
        assign bus.regs_out[k*REG_W +: REG_W] = regs_q[k];
    end

    assign bus.wr_stb = wr_stb_q;
    assign bus.wr_idx = wr_idx_q;

`ifdef FPGA_SPI_SLAVE_READBACK_EN
    logic               sclk_fall_c;
    logic [REG_W-1:0]   rd_word_c;
    logic [REG_W-1:0]   tx_q;
    logic               rd_act_q, miso_q, oe_q;

    assign sclk_fall_c = ~sclk_s & sclk_prev_q;

    // Readback word for the address being decoded; misses read as zero.
    always_comb begin
        rd_word_c = '0;
        for (int unsigned k = 0; k < N_REG; k++) begin
            if (hit_c && (idx_c == IDX_W'(k))) begin
                rd_word_c = regs_q[k];
            end
        end
    end

    // MISO shifter: loaded at decode, advanced on falling edges during DATA only.
    always_ff @(posedge clk_clk or negedge rst_reset_n) begin
        if (!rst_reset_n) begin
            tx_q     <= '0;
            rd_act_q <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            if (decode_c) begin
                rd_act_q <= ~shift_word_c[REG_W-1];
                tx_q     <= rd_word_c;
            end else if (state_d != DATA) begin
                rd_act_q <= 1'b0;
            end
            if (state_d != DATA) begin
                miso_q <= 1'b0;
                oe_q   <= 1'b0;
            end else begin
                oe_q <= decode_c ? ~shift_word_c[REG_W-1] : rd_act_q;
                if (sclk_fall_c && rd_act_q) begin
                    miso_q <= tx_q[REG_W-1];
                    tx_q   <= {tx_q[REG_W-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
`else
    assign bus.spi_miso    = 1'b0;
    assign bus.spi_miso_oe = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_spi_slave_regs.sv
// Directed bench for fpga_spi_slave_regs: SPI master driver, register model and
// write-strobe scoreboard.
`timescale 1ns/1ps
module tb_fpga_spi_slave_regs;
    localparam int unsigned N_REG = 16;
    localparam int unsigned IW    = $clog2(N_REG);
    localparam int unsigned TCLK  = 10;
    localparam int unsigned HALF  = 80;
`ifdef FPGA_SPI_SLAVE_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] data;
    } wr_exp_t;

    logic clk_clk = 1'b0;
    logic rst_reset_n;

    fpga_spi_slave_regs_if #(.N_REG(N_REG)) bus ();

    fpga_spi_slave_regs #(
        .BASE_ADDR (15'h0000),
        .N_REG     (N_REG)
    ) dut (
        .clk_clk     (clk_clk),
        .rst_reset_n (rst_reset_n),
        .bus         (bus)
    );

    always #(TCLK/2) clk_clk = ~clk_clk;

    logic [15:0] model_q [N_REG];
    wr_exp_t     wr_sb [$];
    logic [15:0] rd_sb [$];
    wr_exp_t     mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          stb_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_REG*16-1:0] model_flat();
        logic [N_REG*16-1:0] f;
        for (int k = 0; k < N_REG; k++) f[k*16 +: 16] = model_q[k];
        return f;
    endfunction

    // Write-strobe scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk_clk) begin
        if (bus.wr_stb === 1'b1) begin
            stb_cnt++;
            chk("wr_sb_nonempty", 256'(wr_sb.size() != 0), 256'(1));
            if (wr_sb.size() != 0) begin
                mon_e = wr_sb.pop_front();
                chk("wr_idx", 256'(bus.wr_idx), 256'(mon_e.idx));
                chk("wr_data", 256'(bus.regs_out[mon_e.idx*16 +: 16]), 256'(mon_e.data));
            end
        end
    end

    // One SPI frame; bits taken MSB first from word[39:...]. rst_bit >= 0 pulses reset
    // while sclk is high on that bit.
    task automatic spi_xfer(input logic [39:0] word, input int nbits, input int rst_bit,
                            input int unsigned gap, output logic [15:0] rx,
                            output logic cmd_oe, output logic data_oe);
        rx = '0;
        cmd_oe = 1'b0;
        data_oe = 1'b1;
        bus.spi_ss_n = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = word[39-i];
            #(HALF);
            bus.spi_sclk = 1'b1;
            if (i < 16) cmd_oe = cmd_oe | bus.spi_miso_oe;
            else if (i < 32) begin
                data_oe = data_oe & bus.spi_miso_oe;
                rx = {rx[14:0], bus.spi_miso};
            end
            if (i == rst_bit) begin
                rst_reset_n = 1'b0;
                #(3*TCLK);
                chk("rst_mid_wr_idx", 256'(bus.wr_idx), 256'(0));
                chk("rst_mid_oe", 256'(bus.spi_miso_oe), 256'(0));
                rst_reset_n = 1'b1;
                #(HALF - 3*TCLK);
            end else begin
                #(HALF);
            end
            bus.spi_sclk = 1'b0;
        end
        #(HALF);
        bus.spi_ss_n = 1'b1;
        bus.spi_mosi = 1'b0;
        #(gap*TCLK);
    endtask

    task automatic do_write(input logic [14:0] addr, input logic [15:0] data, input int unsigned gap);
        logic [15:0] rx;
        logic co, dox;
        wr_exp_t e;
        if (addr < 15'(N_REG)) begin
            e.idx = 6'(addr);
            e.data = data;
            wr_sb.push_back(e);
            model_q[IW'(addr)] = data;
        end
        spi_xfer({1'b1, addr, data, 8'h00}, 32, -1, gap, rx, co, dox);
        chk("wr_cmd_oe", 256'(co), 256'(0));
    endtask

    task automatic do_read(input string tag, input logic [14:0] addr);
        logic [15:0] rx, exp;
        logic co, dox;
        exp = 16'h0000;
        if (RB_EN && addr < 15'(N_REG)) exp = model_q[IW'(addr)];
        rd_sb.push_back(exp);
        spi_xfer({1'b0, addr, 16'hC3A5, 8'h00}, 32, -1, 10, rx, co, dox);
        chk({tag, "_data"}, 256'(rx), 256'(rd_sb.pop_front()));
        chk({tag, "_cmd_oe"}, 256'(co), 256'(0));
        chk({tag, "_data_oe"}, 256'(dox), 256'(RB_EN));
        chk({tag, "_idle_oe"}, 256'(bus.spi_miso_oe), 256'(0));
        chk({tag, "_idle_miso"}, 256'(bus.spi_miso), 256'(0));
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        logic co, dox;
        int s0;

        for (int k = 0; k < N_REG; k++) model_q[k] = 16'h0000;
        rst_reset_n  = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        chk("rst_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("rst_wr_stb", 256'(bus.wr_stb), 256'(0));
        chk("rst_wr_idx", 256'(bus.wr_idx), 256'(0));
        chk("rst_miso", 256'(bus.spi_miso), 256'(0));
        chk("rst_oe", 256'(bus.spi_miso_oe), 256'(0));
        rst_reset_n = 1'b1;
        repeat (4) @(negedge clk_clk);

        // Plain write hit to reg3.
        s0 = stb_cnt;
        do_write(15'h0003, 16'hA5A5, 10);
        chk("w3_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("w3_stb_count", 256'(stb_cnt - s0), 256'(1));
        do_read("r3", 15'h0003);

        // Misses above the register range.
        s0 = stb_cnt;
        do_write(15'h0020, 16'h1234, 10);
        do_write(15'h0010, 16'h4321, 10);
        chk("miss_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("miss_stb_count", 256'(stb_cnt - s0), 256'(0));
        do_read("r20", 15'h0020);

        // Last register is a hit.
        s0 = stb_cnt;
        do_write(15'h000F, 16'hC3C3, 10);
        chk("w15_stb_count", 256'(stb_cnt - s0), 256'(1));
        do_read("r15", 15'h000F);

        // Frame aborted after 20 bits, then a complete write.
        s0 = stb_cnt;
        spi_xfer({32'h8001_FFFF, 8'h00}, 20, -1, 10, rx, co, dox);
        chk("abort_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("abort_stb_count", 256'(stb_cnt - s0), 256'(0));
        do_write(15'h0001, 16'h0055, 10);
        chk("w1_regs", 256'(bus.regs_out), 256'(model_flat()));

        // 40 clocks in one select window: trailing 8 bits ignored.
        s0 = stb_cnt;
        wr_sb.push_back('{idx: 6'd2, data: 16'h00FF});
        model_q[2] = 16'h00FF;
        spi_xfer({32'h8002_00FF, 8'hA5}, 40, -1, 10, rx, co, dox);
        chk("long_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("long_stb_count", 256'(stb_cnt - s0), 256'(1));

        // Back-to-back frames with a short deselect gap.
        s0 = stb_cnt;
        do_write(15'h0007, 16'h7A7A, 3);
        do_write(15'h0008, 16'h8B8B, 3);
        do_write(15'h0000, 16'hFFFF, 10);
        chk("b2b_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("b2b_stb_count", 256'(stb_cnt - s0), 256'(3));

        // Reset during the data phase of a write to reg5.
        do_write(15'h0005, 16'h1111, 10);
        s0 = stb_cnt;
        for (int k = 0; k < N_REG; k++) model_q[k] = 16'h0000;
        spi_xfer({32'h8005_BEEF, 8'h00}, 32, 24, 10, rx, co, dox);
        chk("rst_frame_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("rst_frame_stb_count", 256'(stb_cnt - s0), 256'(0));
        chk("rst_frame_wr_idx", 256'(bus.wr_idx), 256'(0));
        do_write(15'h0005, 16'h0F0F, 10);
        chk("post_rst_regs", 256'(bus.regs_out), 256'(model_flat()));
        chk("post_rst_stb_count", 256'(stb_cnt - s0), 256'(1));
        do_read("r5", 15'h0005);

        chk("wr_sb_drained", 256'(wr_sb.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
